stream_serializer: RTL



---
 rtl/stream_serializer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/stream_serializer.sv
// stream_serializer
//   Width-down stream converter. Takes one wide word of RATIO lanes on the
//   sink port and emits it as narrow beats on the source port, lane 0
//   first. last_o marks the final beat of each word. Back-to-back words
//   are sent with no idle cycles.
//
// Optional feature macro: STREAM_SER_PARTIAL_EN
//   When defined, the count_i port exists and each word emits count_i+1
//   beats (lanes 0..count_i). When undefined, every word emits RATIO beats.
//
// Ports:
//   ACLK     in   clock, rising edge
//   ARESET   in   asynchronous active-high reset
//   data_i   in   wide word, lane k = data_i[k*DATA_W +: DATA_W]
//   valid_i  in   wide word valid
//   ready_o  out  serializer can accept a word
//   count_i  in   valid lanes minus 1 (only with STREAM_SER_PARTIAL_EN)
//   data_o   out  current narrow beat
//   valid_o  out  beat valid
//   last_o   out  final beat of the current word
//   ready_i  in   downstream accepts the beat
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no word held; ready_o high, valid_o low
// SEND  | presenting lane idx of the held word; valid_o high
module stream_serializer #(
  parameter int DATA_W = 32,
  parameter int RATIO  = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [DATA_W*RATIO-1:0]    data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
`ifdef STREAM_SER_PARTIAL_EN
  input  logic [$clog2(RATIO)-1:0]   count_i,
`endif
  output logic [DATA_W-1:0]          data_o,
  output logic                       valid_o,
  output logic                       last_o,
  input  logic                       ready_i
);

  localparam int IDX_W = $clog2(RATIO);
  localparam logic [IDX_W-1:0] FIN_FULL = IDX_W'(RATIO - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [DATA_W*RATIO-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [IDX_W-1:0]          fin;
  logic                      busy;
  logic                      acc;
  logic                      tx;
  logic [DATA_W-1:0]         lane [RATIO];

`ifdef STREAM_SER_PARTIAL_EN
  logic [IDX_W-1:0]          fin_q, fin_d;
  assign fin = fin_q;
`else
  // Full words only: the final lane is fixed.
  assign fin = FIN_FULL;
`endif

  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    assign lane[k] = hold_q[k*DATA_W +: DATA_W];
  end

  assign busy    = (state_q == SEND);
  assign valid_o = busy;
  assign last_o  = busy & (idx_q == fin);
  assign data_o  = lane[idx_q];
  assign tx      = valid_o & ready_i;
  // Accepting on the last handshake keeps back-to-back words bubble-free;
  // this is the only combinational input-to-output path (ready_i).
  assign ready_o = ~ARESET & (~busy | (tx & last_o));
  assign acc     = valid_i & ready_o;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
`ifdef STREAM_SER_PARTIAL_EN
    fin_d   = fin_q;
`endif
    if (acc) begin
      state_d = SEND;
      hold_d  = data_i;
      idx_d   = '0;
`ifdef STREAM_SER_PARTIAL_EN
      fin_d   = count_i;
`endif
    end else if (tx) begin
      if (last_o) begin
        state_d = IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
`ifdef STREAM_SER_PARTIAL_EN
      fin_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
`ifdef STREAM_SER_PARTIAL_EN
      fin_q   <= fin_d;
`endif
    end
  end

endmodule
